// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
//  Package    : cnn_pkg
//  Description: Shared defaults and types for the CNN classifier back end.
//               Holds the score width, the class count and the argmax
//               state encoding.
//  Revision   : 1.0 - initial release
// ============================================================================
package cnn_pkg;

  localparam int CNN_DATA_WIDTH  = 32;  // width of one signed class score
  localparam int CNN_CLASSES_QNT = 10;  // beats (classes) per frame

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // waiting for a start-of-frame beat
    ACCUM = 2'd1,  // collecting class scores
    HOLD  = 2'd2   // presenting the result until downstream takes it
  } state_t;

endpackage
`default_nettype wire

// File: rtl/class_argmax.sv
`default_nettype none
// ============================================================================
//  Module     : class_argmax
//  Description: Streams CLASSES_QNT signed scores per frame and reports the
//               index of the largest score, the score itself, the gap to the
//               second-best score and a malformed-frame flag.
//  Revision   : 1.0 - initial release
//
//  Ports
//    clk      in   clock
//    rst      in   asynchronous active-high reset
//    clk_en   in   clock enable; 0 freezes every register
//    i_data   in   signed score beat
//    i_valid  in   beat valid
//    i_sop    in   first beat of frame
//    i_eop    in   last beat of frame
//    o_ready  out  block accepts a beat this cycle (0 while a result is held)
//    o_class  out  index of the maximum score
//    o_score  out  maximum score (signed)
//    o_margin out  best minus second-best, unsigned, saturated
//    o_err    out  malformed frame flag
//    o_valid  out  result valid
//    i_ready  in   downstream accepts the result
// ============================================================================
module class_argmax
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH  = CNN_DATA_WIDTH,
  parameter int CLASSES_QNT = CNN_CLASSES_QNT,
  localparam int IDX_WIDTH  = $clog2(CLASSES_QNT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_en,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_valid,
  input  logic                  i_sop,
  input  logic                  i_eop,
  output logic                  o_ready,
  output logic [IDX_WIDTH-1:0]  o_class,
  output logic [DATA_WIDTH-1:0] o_score,
  output logic [DATA_WIDTH-1:0] o_margin,
  output logic                  o_err,
  output logic                  o_valid,
  input  logic                  i_ready
);

  // Counter must hold CLASSES_QNT itself; it saturates there.
  localparam int CNT_WIDTH = $clog2(CLASSES_QNT + 1);
  localparam logic [CNT_WIDTH-1:0]         CNT_FULL  = CNT_WIDTH'(CLASSES_QNT);
  localparam logic [CNT_WIDTH-1:0]         CNT_ONE   = CNT_WIDTH'(1);
  localparam logic signed [DATA_WIDTH-1:0] SCORE_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  state_t                         state_q, state_d;
  logic [CNT_WIDTH-1:0]           cnt_q, cnt_d;
  logic signed [DATA_WIDTH-1:0]   best_q, best_d;
  logic signed [DATA_WIDTH-1:0]   second_q, second_d;
  logic [IDX_WIDTH-1:0]           cls_q, cls_d;
  logic                           has2_q, has2_d;   // a second score has been seen
  logic                           err_q, err_d;
  logic                           valid_q, valid_d;
  logic                           ready_q, ready_d;
  logic [IDX_WIDTH-1:0]           oclass_q, oclass_d;
  logic [DATA_WIDTH-1:0]          oscore_q, oscore_d;
  logic [DATA_WIDTH-1:0]          omargin_q, omargin_d;
  logic                           oerr_q, oerr_d;

  logic                           accept;
  logic                           finish;
  logic signed [DATA_WIDTH-1:0]   din;
  logic [DATA_WIDTH:0]            diff;
  logic [DATA_WIDTH-1:0]          margin;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    best_d    = best_q;
    second_d  = second_q;
    cls_d     = cls_q;
    has2_d    = has2_q;
    err_d     = err_q;
    valid_d   = valid_q;
    ready_d   = ready_q;
    oclass_d  = oclass_q;
    oscore_d  = oscore_q;
    omargin_d = omargin_q;
    oerr_d    = oerr_q;
    finish    = 1'b0;
    din       = $signed(i_data);
    accept    = i_valid & ready_q & clk_en;

    case (state_q)
      IDLE: begin
        // Beats without sop are dropped here.
        if (accept && i_sop) begin
          best_d   = din;
          second_d = SCORE_MIN;
          cls_d    = '0;
          cnt_d    = CNT_ONE;
          has2_d   = 1'b0;
          err_d    = 1'b0;
          if (i_eop) finish = 1'b1;
          else       state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          if (i_sop) begin
            // Restart on a mid-frame sop, but remember the frame was broken.
            best_d   = din;
            second_d = SCORE_MIN;
            cls_d    = '0;
            cnt_d    = CNT_ONE;
            has2_d   = 1'b0;
            err_d    = 1'b1;
          end else if (cnt_q >= CNT_FULL) begin
            // Surplus beat: flag it, leave the ranking untouched.
            err_d = 1'b1;
          end else begin
            has2_d = 1'b1;
            cnt_d  = cnt_q + CNT_ONE;
            // Strict compare keeps the lower index on ties.
            if (din > best_q) begin
              second_d = best_q;
              best_d   = din;
              cls_d    = cnt_q[IDX_WIDTH-1:0];
            end else if (din > second_q) begin
              second_d = din;
            end
          end
          if (i_eop) finish = 1'b1;
        end
      end
      HOLD: begin
        if (valid_q && i_ready && clk_en) begin
          state_d = IDLE;
          valid_d = 1'b0;
          ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Margin at one extra bit; best >= second so the difference is
    // non-negative. A frame with no second score reports the full range.
    diff = {best_d[DATA_WIDTH-1], best_d} - {second_d[DATA_WIDTH-1], second_d};
    if (!has2_d || diff[DATA_WIDTH]) margin = '1;
    else                             margin = diff[DATA_WIDTH-1:0];

    if (finish) begin
      state_d   = HOLD;
      valid_d   = 1'b1;
      ready_d   = 1'b0;
      oclass_d  = cls_d;
      oscore_d  = best_d;
      omargin_d = margin;
      oerr_d    = err_d | (cnt_d != CNT_FULL);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      best_q    <= '0;
      second_q  <= '0;
      cls_q     <= '0;
      has2_q    <= 1'b0;
      err_q     <= 1'b0;
      valid_q   <= 1'b0;
      ready_q   <= 1'b1;
      oclass_q  <= '0;
      oscore_q  <= '0;
      omargin_q <= '0;
      oerr_q    <= 1'b0;
    end else if (clk_en) begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      best_q    <= best_d;
      second_q  <= second_d;
      cls_q     <= cls_d;
      has2_q    <= has2_d;
      err_q     <= err_d;
      valid_q   <= valid_d;
      ready_q   <= ready_d;
      oclass_q  <= oclass_d;
      oscore_q  <= oscore_d;
      omargin_q <= omargin_d;
      oerr_q    <= oerr_d;
    end
  end

  assign o_ready  = ready_q;
  assign o_valid  = valid_q;
  assign o_class  = oclass_q;
  assign o_score  = oscore_q;
  assign o_margin = omargin_q;
  assign o_err    = oerr_q;

endmodule
`default_nettype wire

// File: tb/tb_class_argmax.sv
`default_nettype none
// ============================================================================
//  Module     : tb_class_argmax
//  Description: Directed self-checking bench for class_argmax.
//  Revision   : 1.0 - initial release
// ============================================================================
module tb_class_argmax;

  localparam int DW = 32;
  localparam int IW = 4;

  typedef logic [31:0] frame10_t [10];

  logic          clk = 1'b0;
  logic          rst;
  logic          clk_en;
  logic [DW-1:0] i_data;
  logic          i_valid, i_sop, i_eop, i_ready;
  logic          o_ready, o_err, o_valid;
  logic [IW-1:0] o_class;
  logic [DW-1:0] o_score, o_margin;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] fr [0:15];

  class_argmax #(.DATA_WIDTH(32), .CLASSES_QNT(10)) dut (
    .clk      (clk),
    .rst      (rst),
    .clk_en   (clk_en),
    .i_data   (i_data),
    .i_valid  (i_valid),
    .i_sop    (i_sop),
    .i_eop    (i_eop),
    .o_ready  (o_ready),
    .o_class  (o_class),
    .o_score  (o_score),
    .o_margin (o_margin),
    .o_err    (o_err),
    .o_valid  (o_valid),
    .i_ready  (i_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] d, input logic s, input logic e);
    i_valid = 1'b1; i_data = d; i_sop = s; i_eop = e;
    tick();
    i_valid = 1'b0; i_sop = 1'b0; i_eop = 1'b0;
  endtask

  task automatic load(input frame10_t f);
    for (int k = 0; k < 10; k++) fr[k] = f[k];
  endtask

  task automatic run_frame(input int n);
    for (int k = 0; k < n; k++) begin
      chk("busy_no_valid", {63'd0, o_valid}, 64'd0);
      beat(fr[k], k == 0, k == n - 1);
    end
  endtask

  task automatic expect_res(input string tag, input logic [IW-1:0] c,
                            input logic [31:0] s, input logic [31:0] m, input logic e);
    chk({tag, "_valid"},  {63'd0, o_valid}, 64'd1);
    chk({tag, "_class"},  {60'd0, o_class}, {60'd0, c});
    chk({tag, "_score"},  {32'd0, o_score}, {32'd0, s});
    chk({tag, "_margin"}, {32'd0, o_margin}, {32'd0, m});
    chk({tag, "_err"},    {63'd0, o_err}, {63'd0, e});
    chk({tag, "_ready"},  {63'd0, o_ready}, 64'd0);
  endtask

  task automatic drain(input string tag);
    i_ready = 1'b1;
    tick();
    chk({tag, "_drain_valid"}, {63'd0, o_valid}, 64'd0);
    chk({tag, "_drain_ready"}, {63'd0, o_ready}, 64'd1);
  endtask

  initial begin
    rst = 1'b1; clk_en = 1'b1; i_valid = 1'b0; i_sop = 1'b0; i_eop = 1'b0;
    i_ready = 1'b1; i_data = '0;
    #3;
    chk("rst_valid",  {63'd0, o_valid}, 64'd0);
    chk("rst_ready",  {63'd0, o_ready}, 64'd1);
    chk("rst_class",  {60'd0, o_class}, 64'd0);
    chk("rst_score",  {32'd0, o_score}, 64'd0);
    chk("rst_margin", {32'd0, o_margin}, 64'd0);
    chk("rst_err",    {63'd0, o_err}, 64'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Tie on 7 keeps index 2.
    load('{3, -1, 7, 2, 7, 0, -5, 1, 6, 4});
    run_frame(10);
    expect_res("basic", 4'd2, 32'd7, 32'd0, 1'b0);
    drain("basic");

    // All negative scores.
    load('{-9, -3, -8, -4, -7, -6, -5, -10, -11, -12});
    run_frame(10);
    expect_res("neg", 4'd1, 32'hFFFF_FFFD, 32'd1, 1'b0);
    drain("neg");

    // Downstream stall for 5 cycles.
    i_ready = 1'b0;
    load('{0, 1, 2, 3, 4, 5, 6, 7, 8, 9});
    run_frame(10);
    for (int k = 0; k < 5; k++) begin
      expect_res("stall", 4'd9, 32'd9, 32'd1, 1'b0);
      tick();
    end
    drain("stall");

    // Short frame.
    load('{5, 1, 2, 3, 4, 6, 0, 0, 0, 0});
    run_frame(7);
    expect_res("short", 4'd5, 32'd6, 32'd1, 1'b1);
    drain("short");

    // Restart by sop at beat 4: result is frame {4,9,1,2,3}.
    beat(32'd10, 1'b1, 1'b0);
    beat(32'd20, 1'b0, 1'b0);
    beat(32'd30, 1'b0, 1'b0);
    beat(32'd4,  1'b1, 1'b0);
    beat(32'd9,  1'b0, 1'b0);
    beat(32'd1,  1'b0, 1'b0);
    beat(32'd2,  1'b0, 1'b0);
    chk("restart_no_valid", {63'd0, o_valid}, 64'd0);
    beat(32'd3,  1'b0, 1'b1);
    expect_res("restart", 4'd1, 32'd9, 32'd5, 1'b1);
    drain("restart");

    // Extreme scores saturate the margin.
    load('{32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
           32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000});
    run_frame(10);
    expect_res("sat", 4'd0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    drain("sat");

    // Beats without sop in IDLE are ignored.
    beat(32'd77, 1'b0, 1'b0);
    beat(32'd78, 1'b0, 1'b0);
    beat(32'd79, 1'b0, 1'b1);
    tick();
    chk("nosop_valid", {63'd0, o_valid}, 64'd0);
    chk("nosop_ready", {63'd0, o_ready}, 64'd1);

    // Single-beat frame.
    beat(32'd5, 1'b1, 1'b1);
    expect_res("single", 4'd0, 32'd5, 32'hFFFF_FFFF, 1'b1);
    drain("single");

    // Surplus beats do not change the ranking.
    load('{0, 1, 2, 3, 4, 5, 6, 7, 8, 9});
    fr[10] = 32'd100;
    fr[11] = 32'd200;
    run_frame(12);
    expect_res("long", 4'd9, 32'd9, 32'd1, 1'b1);
    drain("long");

    // clk_en low mid-frame blocks beats; low in HOLD freezes the result.
    load('{0, 1, 2, 3, 4, 5, 6, 7, 8, 9});
    for (int k = 0; k < 10; k++) begin
      if (k == 5) begin
        clk_en = 1'b0; i_valid = 1'b1; i_data = 32'd1000;
        tick(); tick();
        i_valid = 1'b0; clk_en = 1'b1;
      end
      beat(fr[k], k == 0, k == 9);
    end
    expect_res("cen", 4'd9, 32'd9, 32'd1, 1'b0);
    clk_en = 1'b0;
    tick(); tick();
    expect_res("cen_hold", 4'd9, 32'd9, 32'd1, 1'b0);
    clk_en = 1'b1;
    drain("cen");

    // Reset at beat 5 then a clean frame: only the clean result appears.
    load('{50, 51, 52, 53, 54, 55, 56, 57, 58, 59});
    for (int k = 0; k < 5; k++) beat(fr[k], k == 0, 1'b0);
    #2 rst = 1'b1;
    #2;
    chk("midrst_valid", {63'd0, o_valid}, 64'd0);
    chk("midrst_ready", {63'd0, o_ready}, 64'd1);
    rst = 1'b0;
    tick();
    beat(32'd60, 1'b0, 1'b0);
    beat(32'd61, 1'b0, 1'b1);
    chk("midrst_tail_valid", {63'd0, o_valid}, 64'd0);
    load('{3, -1, 7, 2, 7, 0, -5, 1, 6, 4});
    run_frame(10);
    expect_res("clean", 4'd2, 32'd7, 32'd0, 1'b0);
    drain("clean");
    tick();
    chk("clean_once", {63'd0, o_valid}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
